wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-master Wishbone arbiter placed in front of the fibonacci Wishbone register slave. It shares the single slave port between the Caravel management core (master 0) and a logic-analyzer-driven debug master (master 1). Arbitration is round-robin with bus locking for as long as the granted master holds `cyc`. A per-transfer watchdog terminates strobes that the slave never acknowledges, such as addresses below `BASE_ADDRESS`, so neither master can hang.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width on all three ports.
- `TIMEOUT_CYCLES`, 16: number of un-acked strobe cycles after which the arbiter forces termination; must be ≥ 2.

Ports. `X` stands for `m0` or `m1`; the two master ports are identical.
- `wb_clk_i`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `X_cyc_i`, `X_stb_i`, `X_we_i`  in  1 each  master cycle, strobe and write-enable.
- `X_sel_i`  in  4  byte selects.
- `X_adr_i`  in  `ADDR_WIDTH`  address.
- `X_dat_i`  in  32  write data.
- `X_ack_o`  out  1  acknowledge to master.
- `X_err_o`  out  1  timeout error to master.
- `X_dat_o`  out  32  read data to master.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave cycle, strobe and write-enable.
- `s_sel_o`  out  4  byte selects to slave.
- `s_adr_o`  out  `ADDR_WIDTH`  address to slave.
- `s_dat_o`  out  32  write data to slave.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  32  slave read data.
- `grant_o`  out  2  one-hot current owner; `00` when idle.
- `timeout_irq`  out  1  one-cycle pulse on every forced termination.

## Operation
- States: `IDLE`, `BUSY0`, `BUSY1`.
- Request definition: `reqN = mN_cyc_i & mN_stb_i`.
- Transitions out of `IDLE`:
  - only req0 → `BUSY0`.
  - only req1 → `BUSY1`.
  - both → grant the master that is not `last_grant`.
- `last_grant` is updated on every grant. Its reset value is 1, so m0 wins the first tie.
- `BUSYn` → `IDLE` on the cycle `mn_cyc_i` is sampled low. Bus lock: the grant is held across multiple strobes while `cyc` stays high.
- Handover always passes through `IDLE`; there is no direct `BUSY0` ↔ `BUSY1` transition.
- Slave-side signals in `BUSYn`:
  - `s_*` are driven combinationally from master n.
  - In `IDLE`, all `s_*` are 0.
- Master-side returns in `BUSYn`:
  - `mn_ack_o = s_ack_i & ~force_err`.
  - `mn_dat_o = s_dat_i`.
  - The non-granted master sees ack = err = 0 and dat = 0.
- Watchdog:
  - Counter `wd` is cleared in `IDLE`, on `s_ack_i`, or on a forced termination.
  - Otherwise it increments each cycle in `BUSYn` with `s_stb_o = 1`.
  - `force_err = (wd == TIMEOUT_CYCLES-1) & s_stb_o & ~s_ack_i`.
  - When `force_err` is high: `mn_err_o = 1` and `mn_dat_o = 0`. The same cycle, `timeout_irq` is registered high for the next cycle.
  - The grant is kept after a forced termination; the master decides whether to continue.
- Widths: `wd` is `$clog2(TIMEOUT_CYCLES)` bits. It saturates at its maximum and never wraps.
- Reset mid-transfer:
  - Next state is `IDLE`, with `grant_o = 0`, `wd = 0`, `last_grant = 1`, `timeout_irq = 0`.
  - While `reset` is high, all `ack`/`err`/`dat` outputs and all `s_*` are forced to 0 combinationally.

## Timing
- Grant latency: a request first sampled in `IDLE` at edge N yields `grant_o` and `s_stb_o` valid after edge N.
  - With the fibonacci slave (combinational ack), `mN_ack_o` occurs in cycle N+1: one wait state.
- Subsequent strobes under a held grant pass with zero added latency.
- Release: `cyc` low sampled at edge M → `IDLE` after M; the other master can be granted after edge M+1.
- Timeout: `err` is asserted in the `TIMEOUT_CYCLES`-th cycle of an un-acked strobe; `timeout_irq` follows one cycle later, width 1.
- Ack and timeout in the same cycle: ack wins, because `force_err` requires `~s_ack_i`.
- `err` and `ack` are never asserted simultaneously.

## Structure
- Package `fib_wb_pkg` holds:
  - State encoding localparams `ST_IDLE`/`ST_BUSY0`/`ST_BUSY1`.
  - `GRANT_NONE`/`GRANT_M0`/`GRANT_M1`.
  - Default `TIMEOUT_CYCLES`.
- One sub-module: `wb_watchdog` (inputs: clear, count enable, ack; outputs: `force_err`, `irq` pulse).
- The FSM and muxing stay in `wb_arbiter`.

## Test plan
- Single master, combinational ack: m0 read of 0x30000004 → grant 01 next cycle, `m0_ack_o` with `m0_dat_o = 0x4669626f`; m1 outputs stay 0.
- Simultaneous requests from reset: both masters request → m0 granted first; m0 drops `cyc`; `IDLE` for one cycle; m1 granted and acked.
- Round-robin with repeated contention: four back-to-back contended transfers → grants alternate 01, 10, 01, 10.
- Bus lock: m1 holds `cyc` across 3 strobes while m0 requests → m1 keeps the grant for all 3; m0 is granted only after m1 releases `cyc`.
- Timeout: m0 strobes 0x10000000 and the slave never acks, `TIMEOUT_CYCLES = 16` → `m0_err_o` in cycle 16 of the strobe with `m0_dat_o = 0`; `timeout_irq` one-cycle pulse in cycle 17; no `ack`.
- Reset mid-transfer: `reset` asserted while in `BUSY1` with an un-acked strobe → all outputs 0 immediately; after release, `IDLE`, `wd = 0`, and m0 wins the next tie.

Source files
------------

// File: rtl/fib_wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the
// fibonacci register slave.
//   - State encoding of the arbitration FSM (IDLE / BUSY0 / BUSY1)
//   - One-hot grant encodings reported on grant_o
//   - Default watchdog length in un-acked strobe cycles
package fib_wb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY0 = 2'd1;
  localparam logic [1:0] ST_BUSY1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BUSY0 = ST_BUSY0,
    BUSY1 = ST_BUSY1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone bus bundle used on all three arbiter ports.
//   master modport : drives cyc/stb/we/sel/adr/dat_w, receives dat_r/ack/err
//   slave modport  : receives cyc/stb/we/sel/adr/dat_w, drives dat_r/ack/err
interface wb_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [3:0]            sel;
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  ack;
  logic                  err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_watchdog.sv
// Per-transfer watchdog for the Wishbone arbiter.
// Counts strobe cycles the slave has not acknowledged and forces a
// termination in the TIMEOUT_CYCLES-th such cycle.
// Ports:
//   wb_clk_i, reset : clock, synchronous active-high reset
//   clear           : arbiter idle, counter held at zero
//   count_en        : a strobe is presented to the slave this cycle
//   ack             : slave acknowledge this cycle
//   force_err       : combinational, terminate the current strobe now
//   irq             : registered one-cycle pulse after each force_err
module wb_watchdog
  import fib_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic wb_clk_i,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  input  logic ack,
  output logic force_err,
  output logic irq
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  logic [WD_W-1:0] wd_reg;
  logic [WD_W-1:0] wd_next;
  logic            irq_reg;

  // An ack in the final cycle wins over the timeout.
  assign force_err = (wd_reg == WD_LAST) & count_en & ~ack;
  assign irq       = irq_reg;

  always_comb begin
    wd_next = wd_reg;
    if (clear || ack || force_err) begin
      wd_next = '0;
    end else if (count_en && (wd_reg != WD_MAX)) begin
      // Saturate rather than wrap when the count is held by idle strobes.
      wd_next = wd_reg + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      wd_reg  <= '0;
      irq_reg <= 1'b0;
    end else begin
      wd_reg  <= wd_next;
      irq_reg <= force_err;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter sharing one slave port (fibonacci registers).
// Round-robin on contention, bus locked while the owner holds cyc, and a
// watchdog that terminates strobes the slave never acknowledges.
// Ports:
//   wb_clk_i, reset : clock, synchronous active-high reset
//   m0, m1          : master-facing buses (arbiter acts as their slave)
//   s               : slave-facing bus (arbiter acts as its master)
//   grant_o         : one-hot current owner, 00 when idle
//   timeout_irq     : one-cycle pulse after every forced termination
module wb_arbiter
  import fib_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master s,
  output logic [1:0]   grant_o,
  output logic         timeout_irq
);

  arb_state_e state_reg;
  arb_state_e state_next;
  logic       last_grant_reg;
  logic       last_grant_next;

  logic                  req0;
  logic                  req1;
  logic                  force_err;
  logic                  wd_irq;
  logic [ADDR_WIDTH-1:0] adr_mux;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  // ---------------- arbitration FSM ----------------
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        // On a tie the master that was not granted last wins.
        if (req0 && (!req1 || last_grant_reg)) begin
          state_next      = BUSY0;
          last_grant_next = 1'b0;
        end else if (req1) begin
          state_next      = BUSY1;
          last_grant_next = 1'b1;
        end
      end
      BUSY0: if (!m0.cyc) state_next = IDLE;
      BUSY1: if (!m1.cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // ---------------- slave-side mux ----------------
  // Reset blanks the bus combinationally so a transfer in flight is cut
  // off in the same cycle reset is raised.
  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = '0;
    s.dat_w = '0;
    adr_mux = '0;
    grant_o = GRANT_NONE;
    if (!reset) begin
      case (state_reg)
        BUSY0: begin
          s.cyc   = m0.cyc;
          s.stb   = m0.stb;
          s.we    = m0.we;
          s.sel   = m0.sel;
          s.dat_w = m0.dat_w;
          adr_mux = m0.adr;
          grant_o = GRANT_M0;
        end
        BUSY1: begin
          s.cyc   = m1.cyc;
          s.stb   = m1.stb;
          s.we    = m1.we;
          s.sel   = m1.sel;
          s.dat_w = m1.dat_w;
          adr_mux = m1.adr;
          grant_o = GRANT_M1;
        end
        default: ;
      endcase
    end
  end

  assign s.adr = adr_mux;

  // ---------------- master-side returns ----------------
  // Kept apart from the slave mux: force_err depends on s.stb.
  always_comb begin
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.dat_r = '0;
    if (!reset) begin
      case (state_reg)
        BUSY0: begin
          m0.ack   = s.ack & ~force_err;
          m0.err   = force_err;
          m0.dat_r = force_err ? 32'h0 : s.dat_r;
        end
        BUSY1: begin
          m1.ack   = s.ack & ~force_err;
          m1.err   = force_err;
          m1.dat_r = force_err ? 32'h0 : s.dat_r;
        end
        default: ;
      endcase
    end
  end

  // ---------------- watchdog ----------------
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .clear    (state_reg == IDLE),
    .count_en (s.stb),
    .ack      (s.ack),
    .force_err(force_err),
    .irq      (wd_irq)
  );

  assign timeout_irq = wd_irq & ~reset;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import fib_wb_pkg::*;

  localparam int          T       = 16;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] M0_ADR  = 32'h3000_0004;
  localparam logic [31:0] M1_ADR  = 32'h3000_0008;
  localparam logic [31:0] FIB_RD  = 32'h4669_626f;
  localparam logic [31:0] M1_RD   = 32'h6a5a_0f07;  // M1_ADR ^ 32'h5a5a0f0f
  localparam logic [31:0] BAD_ADR = 32'h1000_0000;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       irq;
  int         total;
  int         bad;

  wb_arbiter_if #(.ADDR_WIDTH(32)) m0_bus ();
  wb_arbiter_if #(.ADDR_WIDTH(32)) m1_bus ();
  wb_arbiter_if #(.ADDR_WIDTH(32)) s_bus ();

  wb_arbiter #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .wb_clk_i   (clk),
    .reset      (rst),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s          (s_bus),
    .grant_o    (grant),
    .timeout_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fibonacci slave stand-in: combinational ack at or above BASE,
  // never acks below it.
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (a == 32'h3000_0004) return FIB_RD;
    return a ^ 32'h5a5a_0f0f;
  endfunction

  assign s_bus.ack   = s_bus.cyc & s_bus.stb & (s_bus.adr >= BASE);
  assign s_bus.dat_r = s_bus.ack ? slave_rd(s_bus.adr) : 32'h0;
  assign s_bus.err   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- master drive helpers ----------------
  task automatic drive(input bit r, input bit c0, input bit s0, input bit c1, input bit s1);
    rst          = r;
    m0_bus.cyc   = c0;  m0_bus.stb = s0;  m0_bus.we = 1'b0;
    m0_bus.sel   = 4'hf; m0_bus.adr = M0_ADR; m0_bus.dat_w = 32'h0;
    m1_bus.cyc   = c1;  m1_bus.stb = s1;  m1_bus.we = 1'b0;
    m1_bus.sel   = 4'hf; m1_bus.adr = M1_ADR; m1_bus.dat_w = 32'h0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    bit         c0, s0, c1, s1;
    logic [1:0] grant;
    bit         ack0, ack1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit c0, input bit s0, input bit c1, input bit s1,
                     input logic [1:0] g, input bit a0, input bit a1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1;
    v.grant = g; v.ack0 = a0; v.ack1 = a1;
    vecs.push_back(v);
  endtask

  // m0 strobes an un-acked address; err must land in strobe cycle T only.
  task automatic timeout_run(input string tag);
    for (int k = 1; k <= T + 2; k++) begin
      @(negedge clk); #1;
      check({tag, "_grant"}, 128'(grant), 128'(GRANT_M0));
      check({tag, "_m0"}, 128'({m0_bus.ack, m0_bus.err, m0_bus.dat_r}),
            128'({1'b0, (k == T), 32'h0}));
      check({tag, "_irq"}, 128'(irq), 128'(k == T + 1));
    end
    $display("%s: %0d strobe cycles observed", tag, T + 2);
  endtask

  // ---------------- reference model state ----------------
  int          owner;
  int          last;
  int          wd;
  bit          irq_m;
  bit          mc[2], ms[2], mw[2];
  logic [3:0]  msel[2];
  logic [31:0] madr[2], mdat[2];

  function automatic logic [31:0] rand_adr();
    if ($urandom_range(0, 3) == 0) return BAD_ADR + 32'($urandom_range(0, 255));
    return BASE + 32'(4 * $urandom_range(0, 15));
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 0, 0, 0, 0);

    // reset, single master, contention from reset, round robin, bus lock
    add(1, 0,0,0,0, 2'b00, 0,0);
    add(0, 0,0,0,0, 2'b00, 0,0);
    add(0, 1,1,0,0, 2'b00, 0,0);
    add(0, 1,1,0,0, 2'b01, 1,0);
    add(0, 0,0,0,0, 2'b01, 0,0);
    add(0, 0,0,0,0, 2'b00, 0,0);
    add(1, 0,0,0,0, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b01, 1,0);
    add(0, 0,0,1,1, 2'b01, 0,0);
    add(0, 0,0,1,1, 2'b00, 0,0);
    add(0, 0,0,1,1, 2'b10, 0,1);
    add(0, 0,0,0,0, 2'b10, 0,0);
    add(0, 1,1,1,1, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b01, 1,0);
    add(0, 0,0,1,1, 2'b01, 0,0);
    add(0, 1,1,1,1, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b10, 0,1);
    add(0, 1,1,0,0, 2'b10, 0,0);
    add(0, 1,1,1,1, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b01, 1,0);
    add(0, 0,0,1,1, 2'b01, 0,0);
    add(0, 1,1,1,1, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b10, 0,1);
    add(0, 0,0,0,0, 2'b10, 0,0);
    add(0, 0,0,0,0, 2'b00, 0,0);
    add(0, 0,0,1,1, 2'b00, 0,0);
    add(0, 1,1,1,1, 2'b10, 0,1);
    add(0, 1,1,1,0, 2'b10, 0,0);
    add(0, 1,1,1,1, 2'b10, 0,1);
    add(0, 1,1,1,1, 2'b10, 0,1);
    add(0, 1,1,0,0, 2'b10, 0,0);
    add(0, 1,1,0,0, 2'b00, 0,0);
    add(0, 1,1,0,0, 2'b01, 1,0);
    add(0, 0,0,0,0, 2'b01, 0,0);
    add(0, 0,0,0,0, 2'b00, 0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1);
      #1;
      check("vec_grant", 128'(grant), 128'(vecs[i].grant));
      check("vec_m0", 128'({m0_bus.ack, m0_bus.err, m0_bus.dat_r}),
            128'({vecs[i].ack0, 1'b0, vecs[i].ack0 ? FIB_RD : 32'h0}));
      check("vec_m1", 128'({m1_bus.ack, m1_bus.err, m1_bus.dat_r}),
            128'({vecs[i].ack1, 1'b0, vecs[i].ack1 ? M1_RD : 32'h0}));
      $display("vec %0d: rst=%0b req=%0b%0b%0b%0b grant=%b ack=%0b%0b",
               i, vecs[i].rst, vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1,
               grant, m0_bus.ack, m1_bus.ack);
    end

    // ---------------- timeout on an un-acked address ----------------
    @(negedge clk);
    drive(1'b0, 1, 1, 0, 0);
    m0_bus.adr = BAD_ADR;
    #1;
    check("to_idle", 128'(grant), 128'(GRANT_NONE));
    timeout_run("timeout");
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0);
    @(negedge clk);

    // ---------------- reset in the middle of a BUSY1 transfer ----------------
    drive(1'b0, 0, 0, 1, 1);
    m1_bus.adr = BAD_ADR;
    for (int k = 0; k < 7; k++) @(negedge clk);
    #1;
    check("rst_pre_grant", 128'(grant), 128'(GRANT_M1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_grant", 128'(grant), 128'(GRANT_NONE));
    check("rst_slave", 128'({s_bus.cyc, s_bus.stb, s_bus.adr}), 128'(0));
    check("rst_m1", 128'({m1_bus.ack, m1_bus.err, m1_bus.dat_r}), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    @(negedge clk);
    drive(1'b0, 1, 1, 1, 1);
    m0_bus.adr = BAD_ADR;
    m1_bus.adr = BAD_ADR;
    #1;
    check("rst_idle", 128'(grant), 128'(GRANT_NONE));
    timeout_run("post_reset");
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0);

    // ---------------- randomized run against the reference model ----------------
    owner = -1; last = 1; wd = 0; irq_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 1'b0; ms[i] = 1'b0; mw[i] = 1'b0;
      msel[i] = 4'h0; madr[i] = BASE; mdat[i] = 32'h0;
    end
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      bit          r, fe, sack;
      logic [1:0]  eg;
      logic        ecyc, estb, ewe;
      logic [3:0]  esel;
      logic [31:0] eadr, edat, sdat;
      logic [33:0] em[2];

      @(negedge clk);
      r = (cyc_n == 0) || ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 9) == 0) mc[i] = ~mc[i];
        ms[i] = mc[i] && ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) madr[i] = rand_adr();
        mw[i]   = 1'($urandom_range(0, 1));
        msel[i] = 4'($urandom_range(0, 15));
        mdat[i] = $urandom;
      end
      rst = r;
      m0_bus.cyc = mc[0]; m0_bus.stb = ms[0]; m0_bus.we = mw[0];
      m0_bus.sel = msel[0]; m0_bus.adr = madr[0]; m0_bus.dat_w = mdat[0];
      m1_bus.cyc = mc[1]; m1_bus.stb = ms[1]; m1_bus.we = mw[1];
      m1_bus.sel = msel[1]; m1_bus.adr = madr[1]; m1_bus.dat_w = mdat[1];
      #1;

      // Expected outputs for this cycle from the model's view of ownership.
      eg = 2'b00; ecyc = 0; estb = 0; ewe = 0; esel = 0; eadr = 0; edat = 0;
      if (!r && owner >= 0) begin
        eg   = (owner == 0) ? 2'b01 : 2'b10;
        ecyc = mc[owner]; estb = ms[owner]; ewe = mw[owner];
        esel = msel[owner]; eadr = madr[owner]; edat = mdat[owner];
      end
      sack = ecyc && estb && (eadr >= BASE);
      sdat = sack ? slave_rd(eadr) : 32'h0;
      fe   = !r && owner >= 0 && estb && !sack && (wd == T - 1);
      for (int i = 0; i < 2; i++) begin
        em[i] = '0;
        if (!r && owner == i) em[i] = {sack && !fe, fe, fe ? 32'h0 : sdat};
      end

      check("rnd_grant", 128'(grant), 128'(eg));
      check("rnd_slave",
            128'({s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.adr, s_bus.dat_w}),
            128'({ecyc, estb, ewe, esel, eadr, edat}));
      check("rnd_m0", 128'({m0_bus.ack, m0_bus.err, m0_bus.dat_r}), 128'(em[0]));
      check("rnd_m1", 128'({m1_bus.ack, m1_bus.err, m1_bus.dat_r}), 128'(em[1]));
      check("rnd_irq", 128'(irq), 128'(!r && irq_m));

      @(posedge clk);
      if (r) begin
        owner = -1; last = 1; wd = 0; irq_m = 1'b0;
      end else begin
        irq_m = fe;
        if (owner < 0 || sack || fe) wd = 0;
        else if (estb) wd = wd + 1;
        if (owner < 0) begin
          bit r0, r1;
          r0 = mc[0] && ms[0];
          r1 = mc[1] && ms[1];
          if (r0 && r1) owner = (last == 0) ? 1 : 0;
          else if (r0)  owner = 0;
          else if (r1)  owner = 1;
          if (owner >= 0) last = owner;
        end else if (!mc[owner]) begin
          owner = -1;
        end
      end
    end
    $display("random run: 3000 cycles compared against model");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
